// File: rtl/noc1_out_pkg.sv
// Shared types and default geometry for the NoC1 output credit buffer.
// Holds the packet-tracking state encoding and the default counter widths.
package noc1_out_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BODY = 1'b1
    } pkt_state_e;

    localparam int DATA_WIDTH_DEF = 64;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int CREDIT_MAX_DEF = 4;
    localparam int LEN_LSB_DEF    = 22;
    localparam int LEN_WIDTH_DEF  = 8;

    localparam int CNT_W = $clog2(FIFO_DEPTH_DEF + 1);
    localparam int CRD_W = $clog2(CREDIT_MAX_DEF + 1);

endpackage

// File: rtl/noc1_out_fifo.sv
// Small synchronous FIFO with occupancy count and a combinational head output.
// Depth must be a power of two so the pointers wrap naturally.
module noc1_out_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_WIDTH-1:0]      din,
    output logic [DATA_WIDTH-1:0]      head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [CNT_W-1:0]      count_r;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = (count_r == CNT_W'(DEPTH));
    assign empty = (count_r == CNT_W'(0));

endmodule

// File: rtl/noc1_out_credit_buffer.sv
// NoC1 output stage: buffers encoder flits and forwards them to the router
// under yummy credit flow control, tracking packet framing on ingress.
module noc1_out_credit_buffer
    import noc1_out_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int CREDIT_MAX = CREDIT_MAX_DEF,
    parameter int LEN_LSB    = LEN_LSB_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            noc1encoder_noc1out_val,
    input  logic [DATA_WIDTH-1:0]           noc1encoder_noc1out_data,
    output logic                            noc1out_ready,
    output logic                            noc1_out_val,
    output logic [DATA_WIDTH-1:0]           noc1_out_data,
    input  logic                            noc1_out_yummy,
    output logic [$clog2(CREDIT_MAX+1)-1:0] noc1_credits,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] noc1_fifo_count,
    output logic                            noc1_pkt_busy,
    output logic                            noc1_credit_err
);

    localparam int CRD_WL = $clog2(CREDIT_MAX + 1);

    logic                  push_s;
    logic                  send_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [DATA_WIDTH-1:0] head_s;
    logic [LEN_WIDTH-1:0]  len_s;

    logic                  out_val_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic [CRD_WL-1:0]     credits_r;
    logic [CRD_WL-1:0]     credits_next_s;
    logic                  err_r;
    logic                  err_next_s;
    pkt_state_e            state_r;
    pkt_state_e            state_next_s;
    logic [LEN_WIDTH-1:0]  remaining_r;
    logic [LEN_WIDTH-1:0]  remaining_next_s;

    assign noc1out_ready = !fifo_full_s;
    assign push_s        = noc1encoder_noc1out_val && !fifo_full_s;
    assign send_s        = !fifo_empty_s && (credits_r != CRD_WL'(0));
    assign len_s         = noc1encoder_noc1out_data[LEN_LSB +: LEN_WIDTH];

    noc1_out_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (send_s),
        .din   (noc1encoder_noc1out_data),
        .head  (head_s),
        .count (noc1_fifo_count),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Router-side flit register; data holds between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_val_r  <= 1'b0;
            out_data_r <= '0;
        end else begin
            out_val_r <= send_s;
            if (send_s) begin
                out_data_r <= head_s;
            end
        end
    end

    // Credit update; a yummy at full credit saturates and flags a protocol error.
    always_comb begin
        credits_next_s = credits_r;
        err_next_s     = err_r;
        case ({send_s, noc1_out_yummy})
            2'b10: credits_next_s = credits_r - CRD_WL'(1);
            2'b01: begin
                if (credits_r == CRD_WL'(CREDIT_MAX)) begin
                    err_next_s = 1'b1;
                end else begin
                    credits_next_s = credits_r + CRD_WL'(1);
                end
            end
            default: credits_next_s = credits_r;
        endcase
    end

    // Packet framing: a header with non-zero length opens a body of that many flits.
    always_comb begin
        state_next_s     = state_r;
        remaining_next_s = remaining_r;
        if (push_s) begin
            case (state_r)
                IDLE: begin
                    if (len_s != LEN_WIDTH'(0)) begin
                        state_next_s     = BODY;
                        remaining_next_s = len_s;
                    end else begin
                        state_next_s     = IDLE;
                    end
                end
                BODY: begin
                    remaining_next_s = remaining_r - LEN_WIDTH'(1);
                    if (remaining_r == LEN_WIDTH'(1)) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = BODY;
                    end
                end
                default: begin
                    state_next_s     = IDLE;
                    remaining_next_s = LEN_WIDTH'(0);
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Credit, error and framing state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            credits_r   <= CRD_WL'(CREDIT_MAX);
            err_r       <= 1'b0;
            state_r     <= IDLE;
            remaining_r <= LEN_WIDTH'(0);
        end else begin
            credits_r   <= credits_next_s;
            err_r       <= err_next_s;
            state_r     <= state_next_s;
            remaining_r <= remaining_next_s;
        end
    end

    assign noc1_out_val    = out_val_r;
    assign noc1_out_data   = out_data_r;
    assign noc1_credits    = credits_r;
    assign noc1_credit_err = err_r;
    assign noc1_pkt_busy   = (state_r == BODY);

endmodule

// File: tb/tb_noc1_out_credit_buffer.sv
// Self-checking bench for noc1_out_credit_buffer: per-cycle vector table plus
// hand-written stall/credit/reset sequences, with a flit-order scoreboard.
module tb_noc1_out_credit_buffer;
    import noc1_out_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              val = 1'b0;
    logic [63:0]       data = 64'h0;
    logic              yummy = 1'b0;
    logic              noc1out_ready;
    logic              noc1_out_val;
    logic [63:0]       noc1_out_data;
    logic [CRD_W-1:0]  noc1_credits;
    logic [CNT_W-1:0]  noc1_fifo_count;
    logic              noc1_pkt_busy;
    logic              noc1_credit_err;

    int checks = 0;
    int errors = 0;
    int strobes = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic             val;
        logic [63:0]      data;
        logic             yummy;
        logic             exp_val;
        logic [CRD_W-1:0] exp_cred;
        logic [CNT_W-1:0] exp_cnt;
        logic             exp_busy;
    } vec_t;

    vec_t vecs[11];

    noc1_out_credit_buffer dut (
        .clk                      (clk),
        .rst                      (rst),
        .noc1encoder_noc1out_val  (val),
        .noc1encoder_noc1out_data (data),
        .noc1out_ready            (noc1out_ready),
        .noc1_out_val             (noc1_out_val),
        .noc1_out_data            (noc1_out_data),
        .noc1_out_yummy           (yummy),
        .noc1_credits             (noc1_credits),
        .noc1_fifo_count          (noc1_fifo_count),
        .noc1_pkt_busy            (noc1_pkt_busy),
        .noc1_credit_err          (noc1_credit_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every router strobe must carry the oldest accepted flit.
    always @(negedge clk) begin
        if (!rst && noc1_out_val) begin
            strobes++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual=%0h required=none", noc1_out_data);
            end else begin
                chk("sb_data", noc1_out_data, exp_q.pop_front());
            end
        end
    end

    // One clock: record accepted flit, advance to the next falling edge.
    task automatic cycle();
        if (rst) exp_q.delete();
        else if (val && noc1out_ready) exp_q.push_back(data);
        @(negedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        val = 1'b0;
        while ((noc1_fifo_count != 3'd0 || noc1_credits != 3'd4) && n < 50) begin
            yummy = (noc1_credits != 3'd4);
            cycle();
            n++;
        end
        yummy = 1'b0;
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d required=<50", n);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 64'h0,                   1'b0, 1'b0, 3'd4, 3'd1, 1'b0};
        vecs[1]  = '{1'b0, 64'h0,                   1'b0, 1'b1, 3'd3, 3'd0, 1'b0};
        vecs[2]  = '{1'b0, 64'h0,                   1'b0, 1'b0, 3'd3, 3'd0, 1'b0};
        vecs[3]  = '{1'b1, 64'h0000_0000_0080_0000, 1'b0, 1'b0, 3'd3, 3'd1, 1'b1};
        vecs[4]  = '{1'b1, 64'h0000_0000_0000_1111, 1'b0, 1'b1, 3'd2, 3'd1, 1'b1};
        vecs[5]  = '{1'b1, 64'h0000_0000_0000_2222, 1'b0, 1'b1, 3'd1, 3'd1, 1'b0};
        vecs[6]  = '{1'b0, 64'h0,                   1'b1, 1'b1, 3'd1, 3'd0, 1'b0};
        vecs[7]  = '{1'b0, 64'h0,                   1'b1, 1'b0, 3'd2, 3'd0, 1'b0};
        vecs[8]  = '{1'b0, 64'h0,                   1'b1, 1'b0, 3'd3, 3'd0, 1'b0};
        vecs[9]  = '{1'b0, 64'h0,                   1'b1, 1'b0, 3'd4, 3'd0, 1'b0};
        vecs[10] = '{1'b0, 64'h0,                   1'b0, 1'b0, 3'd4, 3'd0, 1'b0};

        cycle();
        cycle();
        rst = 1'b0;
        chk("rst_out_val", noc1_out_val, 1'b0);
        chk("rst_out_data", noc1_out_data, 64'h0);
        chk("rst_credits", noc1_credits, 3'd4);
        chk("rst_count", noc1_fifo_count, 3'd0);
        chk("rst_busy", noc1_pkt_busy, 1'b0);
        chk("rst_err", noc1_credit_err, 1'b0);
        chk("rst_ready", noc1out_ready, 1'b1);

        // Single len=0 header, then len=2 packet, then credit return.
        for (int i = 0; i < 11; i++) begin
            val   = vecs[i].val;
            data  = vecs[i].data;
            yummy = vecs[i].yummy;
            cycle();
            chk($sformatf("vec%0d_out_val", i), noc1_out_val, vecs[i].exp_val);
            chk($sformatf("vec%0d_credits", i), noc1_credits, vecs[i].exp_cred);
            chk($sformatf("vec%0d_count", i), noc1_fifo_count, vecs[i].exp_cnt);
            chk($sformatf("vec%0d_busy", i), noc1_pkt_busy, vecs[i].exp_busy);
            chk($sformatf("vec%0d_err", i), noc1_credit_err, 1'b0);
        end
        val = 1'b0;
        yummy = 1'b0;

        // Zero-credit stall: 8 flits, 4 go out, 4 stay buffered.
        strobes = 0;
        for (int i = 0; i < 8; i++) begin
            val  = 1'b1;
            data = 64'h0000_0000_0000_A000 + 64'(i);
            cycle();
        end
        val = 1'b0;
        chk("stall_count", noc1_fifo_count, 3'd4);
        chk("stall_ready", noc1out_ready, 1'b0);
        chk("stall_credits", noc1_credits, 3'd0);
        chk("stall_strobes", strobes, 4);
        yummy = 1'b1;
        cycle();
        yummy = 1'b0;
        chk("yum_out_val0", noc1_out_val, 1'b0);
        chk("yum_credits1", noc1_credits, 3'd1);
        cycle();
        chk("yum_out_val1", noc1_out_val, 1'b1);
        chk("yum_count", noc1_fifo_count, 3'd3);
        chk("yum_ready", noc1out_ready, 1'b1);
        chk("yum_credits0", noc1_credits, 3'd0);
        cycle();
        cycle();
        chk("yum_strobes", strobes, 5);
        drain();

        // Send and yummy in the same cycle at credits=2.
        val = 1'b1; data = 64'h0000_0000_0000_00C1; cycle();
        val = 1'b1; data = 64'h0000_0000_0000_00C2; cycle();
        val = 1'b0; cycle();
        chk("sim_pre_credits", noc1_credits, 3'd2);
        val = 1'b1; data = 64'h0000_0000_0000_00C3; cycle();
        val = 1'b0; yummy = 1'b1; cycle();
        yummy = 1'b0;
        chk("sim_out_val", noc1_out_val, 1'b1);
        chk("sim_credits", noc1_credits, 3'd2);
        chk("sim_err", noc1_credit_err, 1'b0);
        drain();

        // Yummy at full credit while idle: saturate and latch error.
        yummy = 1'b1;
        cycle();
        yummy = 1'b0;
        chk("ovf_credits", noc1_credits, 3'd4);
        chk("ovf_err", noc1_credit_err, 1'b1);
        val = 1'b1; data = 64'h0000_0000_0000_00E1; cycle();
        val = 1'b0; cycle(); cycle();
        chk("ovf_err_sticky", noc1_credit_err, 1'b1);
        chk("ovf_credits_after", noc1_credits, 3'd3);
        drain();

        // Reset with three flits buffered mid-packet (remaining=5).
        for (int i = 0; i < 4; i++) begin
            val = 1'b1; data = 64'h0000_0000_0000_0D00 + 64'(i); cycle();
        end
        val = 1'b1; data = 64'h0000_0000_01C0_0000; cycle();
        val = 1'b1; data = 64'h0000_0000_0000_0B01; cycle();
        val = 1'b1; data = 64'h0000_0000_0000_0B02; cycle();
        val = 1'b0;
        chk("mid_count", noc1_fifo_count, 3'd3);
        chk("mid_busy", noc1_pkt_busy, 1'b1);
        chk("mid_credits", noc1_credits, 3'd0);
        rst = 1'b1; yummy = 1'b1; cycle();
        rst = 1'b0; yummy = 1'b0;
        chk("mrst_count", noc1_fifo_count, 3'd0);
        chk("mrst_credits", noc1_credits, 3'd4);
        chk("mrst_busy", noc1_pkt_busy, 1'b0);
        chk("mrst_out_val", noc1_out_val, 1'b0);
        chk("mrst_err", noc1_credit_err, 1'b0);
        val = 1'b1; data = 64'h0000_0000_0000_0005; cycle();
        val = 1'b0;
        chk("post_busy", noc1_pkt_busy, 1'b0);
        chk("post_count", noc1_fifo_count, 3'd1);
        cycle();
        chk("post_out_val", noc1_out_val, 1'b1);
        drain();
        chk("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/noc1_out_credit_buffer.md
Name: noc1_out_credit_buffer

Overview:
- Output stage directly downstream of the NoC1 encoder in the L1.5.
- Accepts 64-bit NoC1 flits on the encoder's val/rdy interface and buffers them in a small FIFO.
- Forwards flits to the NoC1 router port under credit-based ("yummy") flow control.
- Tracks packet framing from the header length field, so downstream debug/perf logic sees packet boundaries and an in-flight indication.

Parameters:
- DATA_WIDTH, 64, flit width.
- FIFO_DEPTH, 4, ingress FIFO entries (power of 2, at least 2).
- CREDIT_MAX, 4, router input buffer depth; this is the credit counter reset value.
- LEN_LSB, 22, LSB of the header payload-length field.
- LEN_WIDTH, 8, width of the payload-length field (field is [LEN_LSB+LEN_WIDTH-1:LEN_LSB]).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- noc1encoder_noc1out_val  in  1  flit valid from encoder
- noc1encoder_noc1out_data  in  DATA_WIDTH  flit from encoder
- noc1out_ready  out  1  buffer can accept a flit this cycle
- noc1_out_val  out  1  one-cycle flit strobe to router
- noc1_out_data  out  DATA_WIDTH  flit to router
- noc1_out_yummy  in  1  credit return pulse from router (one credit per cycle high)
- noc1_credits  out  $clog2(CREDIT_MAX+1)  current credit count
- noc1_fifo_count  out  $clog2(FIFO_DEPTH+1)  current occupancy
- noc1_pkt_busy  out  1  ingress is mid-packet (header accepted, body flits outstanding)
- noc1_credit_err  out  1  sticky: yummy received while credits == CREDIT_MAX

Behaviour:
Interfaces and reset
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: noc1_out_val=0, noc1_out_data=0, noc1_credits=CREDIT_MAX, noc1_fifo_count=0, noc1_pkt_busy=0, noc1_credit_err=0, FIFO pointers=0, FSM=IDLE.
- Reset mid-packet discards all buffered flits and packet state. Any yummy arriving during reset is ignored.

Ingress
- noc1out_ready = (fifo_count < FIFO_DEPTH). It depends only on registered state, never on val.
- Push when val && ready.
- Push and pop in the same cycle are legal at any occupancy below full; the count is then unchanged.

Egress
- send = (fifo_count != 0) && (credits != 0), evaluated combinationally from registered state.
- At the edge where send=1: pop the head, noc1_out_val<=1, noc1_out_data<=head. Otherwise noc1_out_val<=0 and noc1_out_data holds its previous value.
- Latency: a flit pushed into an empty FIFO at edge k appears on noc1_out_val/data after edge k+1, provided credits > 0.
- Back-to-back: one flit per cycle while credits and FIFO allow.
- Order is strictly FIFO. Pointers wrap modulo FIFO_DEPTH.

Credits
- credits_next = credits - send + yummy.
- Simultaneous send and yummy leaves the count unchanged.
- A yummy when credits == CREDIT_MAX and send=0 saturates the count at CREDIT_MAX and sets noc1_credit_err. The error clears only on rst.
- At credits == 0, egress stalls and the FIFO fills. noc1out_ready drops once the FIFO is full.

Packet tracking FSM (ingress side, advances on push only)
- IDLE: a pushed flit is a header. If len == 0, stay in IDLE. Otherwise load remaining=len and go to BODY.
- BODY: each push decrements remaining. When a push occurs with remaining == 1, go to IDLE.
- noc1_pkt_busy = (state == BODY).
- Maximum body is 255 flits. Remaining has width LEN_WIDTH.

Decomposition:
- Shared package noc1_out_pkg holds:
  - state enum {IDLE, BODY};
  - localparams for the default length field position (22, 8);
  - widths CNT_W=$clog2(FIFO_DEPTH+1) and CRD_W=$clog2(CREDIT_MAX+1).
- One sub-module, noc1_out_fifo: a synchronous FIFO with push/pop/count/full/empty and a head data output.
- The top level holds the credit counter, output register and packet FSM.

Test Plan:
- Single header flit 0x0000_0000_0000_0000 (len=0), credits=4 -> noc1_out_val high for exactly one cycle, after edge k+1; credits go to 3; pkt_busy never asserts.
- Header with len=2, then 2 body flits back-to-back, no yummy -> 3 strobes on consecutive cycles in order; credits=1; pkt_busy high between header push and last body push.
- Zero-credit stall: CREDIT_MAX=4, push 8 flits with no yummy -> 4 sent; FIFO holds 4; noc1out_ready=0. One yummy pulse -> exactly one more flit sent one edge later; ready reasserts.
- Simultaneous yummy and send at credits=2 -> credits stay 2 for that cycle; no err.
- Yummy at credits=4 while idle -> credits stay 4; noc1_credit_err=1 and stays set until rst.
- rst asserted with 3 flits buffered mid-packet (remaining=5) -> next cycle fifo_count=0, credits=4, pkt_busy=0, noc1_out_val=0. The next pushed flit is treated as a header.
